// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: control-word bit positions,
// ALU operation codes and the multiply sequencing states.
package ex_pkg;

    localparam int CTL_REG_WRITE = 7;
    localparam int CTL_MEM_READ  = 6;
    localparam int CTL_MEM_WRITE = 5;
    localparam int CTL_USE_IMM   = 4;
    localparam int CTL_JEQ       = 3;
    localparam int CTL_JMP       = 2;
    localparam int CTL_ALU_HI    = 1;
    localparam int CTL_ALU_LO    = 0;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_NAND = 2'b10,
        ALU_MUL  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, forwarding sources and EX/MEM / hazard outputs of the
// execute stage, bundled so the pipeline top wires a single port.
interface ex_stage_if #(
    parameter int DW = 16
);
    logic [7:0]    ControlsIn;
    logic [DW-1:0] Data1In;
    logic [DW-1:0] Data2In;
    logic [DW-1:0] JEQAddrIn;
    logic [DW-1:0] JMPAddrIn;
    logic [7:0]    Imm8In;
    logic [2:0]    Reg1In;
    logic [2:0]    Reg2In;
    logic          MemWbRegWrite;
    logic [2:0]    MemWbReg;
    logic [DW-1:0] MemWbData;

    logic          Stall;
    logic          Flush;
    logic          PcLoad;
    logic [DW-1:0] PcTarget;
    logic          ExMemRegWrite;
    logic          ExMemMemRead;
    logic          ExMemMemWrite;
    logic [DW-1:0] ExMemResult;
    logic [DW-1:0] ExMemStoreData;
    logic [2:0]    ExMemReg;

    modport master (
        output ControlsIn, Data1In, Data2In, JEQAddrIn, JMPAddrIn, Imm8In,
               Reg1In, Reg2In, MemWbRegWrite, MemWbReg, MemWbData,
        input  Stall, Flush, PcLoad, PcTarget, ExMemRegWrite, ExMemMemRead,
               ExMemMemWrite, ExMemResult, ExMemStoreData, ExMemReg
    );

    modport slave (
        input  ControlsIn, Data1In, Data2In, JEQAddrIn, JMPAddrIn, Imm8In,
               Reg1In, Reg2In, MemWbRegWrite, MemWbReg, MemWbData,
        output Stall, Flush, PcLoad, PcTarget, ExMemRegWrite, ExMemMemRead,
               ExMemMemWrite, ExMemResult, ExMemStoreData, ExMemReg
    );

endinterface

// File: rtl/ex_stage_mul_seq.sv
// Unsigned shift-add multiplier: one partial product per cycle for DW
// cycles after a start pulse, product truncated to DW bits.
module mul_seq
    import ex_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          last,
    output logic          done,
    output logic [DW-1:0] product
);
    localparam int CW = $clog2(DW);

    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] mcand_q, mcand_d;
    logic [DW-1:0] mplier_q, mplier_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (busy_q) begin
            // Multiplicand bits shifted past DW fall away, giving mod 2^DW.
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (start) begin
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = CW'(DW - 1);
            busy_d   = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy    = busy_q;
    assign last    = busy_q && (cnt_q == '0);
    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution, the multiply
// sequencer and the EX/MEM pipeline register.
module ex_stage
    import ex_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic      Clk,
    input  logic      Reset,
    ex_stage_if.slave bus
);
    mul_state_e    state_q, state_d;
    logic [2:0]    mul_reg_q, mul_reg_d;
    logic          mul_rw_q, mul_rw_d;
    logic          ex_rw_q, ex_rw_d;
    logic          ex_mr_q, ex_mr_d;
    logic          ex_mw_q, ex_mw_d;
    logic [DW-1:0] ex_result_q, ex_result_d;
    logic [DW-1:0] ex_store_q, ex_store_d;
    logic [2:0]    ex_reg_q, ex_reg_d;

    logic [7:0]    ctl;
    alu_op_e       alu_op;
    logic          is_bubble, is_mul, is_branch, take_branch, mul_start;
    logic          mul_busy, mul_last, mul_done;
    logic [DW-1:0] fwd_a, fwd_b, imm_ext, op_b, sum, alu_res, mul_product;

    assign ctl       = bus.ControlsIn;
    assign alu_op    = alu_op_e'(ctl[CTL_ALU_HI:CTL_ALU_LO]);
    assign is_bubble = (ctl == '0);
    assign is_mul    = (alu_op == ALU_MUL);
    assign is_branch = ctl[CTL_JEQ] | ctl[CTL_JMP];

    // A load still in EX/MEM has no data yet, so it is never a forwarding source.
    always_comb begin
        fwd_a = bus.Data1In;
        if (ex_rw_q && !ex_mr_q && (ex_reg_q == bus.Reg1In)) begin
            fwd_a = ex_result_q;
        end else if (bus.MemWbRegWrite && (bus.MemWbReg == bus.Reg1In)) begin
            fwd_a = bus.MemWbData;
        end
        fwd_b = bus.Data2In;
        if (ex_rw_q && !ex_mr_q && (ex_reg_q == bus.Reg2In)) begin
            fwd_b = ex_result_q;
        end else if (bus.MemWbRegWrite && (bus.MemWbReg == bus.Reg2In)) begin
            fwd_b = bus.MemWbData;
        end
    end

    assign imm_ext = {{(DW-8){bus.Imm8In[7]}}, bus.Imm8In};
    assign op_b    = ctl[CTL_USE_IMM] ? imm_ext : fwd_b;
    assign sum     = fwd_a + op_b;

    always_comb begin
        alu_res = sum;
        if (!(ctl[CTL_MEM_READ] | ctl[CTL_MEM_WRITE])) begin
            case (alu_op)
                ALU_SUB:  alu_res = fwd_a - op_b;
                ALU_NAND: alu_res = ~(fwd_a & op_b);
                default:  alu_res = sum;
            endcase
        end
    end

    // A MUL in the same slot wins over branch bits so Stall and Flush never overlap.
    assign take_branch = (state_q == IDLE) && !is_mul &&
                         (ctl[CTL_JMP] || (ctl[CTL_JEQ] && (fwd_a == fwd_b)));
    assign mul_start   = (state_q == IDLE) && is_mul;

    assign bus.Stall    = !Reset && (mul_start || mul_busy);
    assign bus.Flush    = !Reset && take_branch;
    assign bus.PcLoad   = !Reset && take_branch;
    assign bus.PcTarget = (!Reset && take_branch) ?
                          (ctl[CTL_JMP] ? bus.JMPAddrIn : bus.JEQAddrIn) : '0;

    mul_seq #(.DW(DW)) u_mul (
        .Clk     (Clk),
        .Reset   (Reset),
        .start   (mul_start),
        .a       (fwd_a),
        .b       (op_b),
        .busy    (mul_busy),
        .last    (mul_last),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d     = state_q;
        mul_reg_d   = mul_reg_q;
        mul_rw_d    = mul_rw_q;
        ex_rw_d     = 1'b0;
        ex_mr_d     = 1'b0;
        ex_mw_d     = 1'b0;
        ex_result_d = '0;
        ex_store_d  = '0;
        ex_reg_d    = '0;
        case (state_q)
            IDLE: begin
                if (is_mul) begin
                    state_d   = BUSY;
                    mul_reg_d = bus.Reg1In;
                    mul_rw_d  = ctl[CTL_REG_WRITE];
                end else if (!is_bubble && !is_branch) begin
                    ex_rw_d     = ctl[CTL_REG_WRITE];
                    ex_mr_d     = ctl[CTL_MEM_READ];
                    ex_mw_d     = ctl[CTL_MEM_WRITE];
                    ex_result_d = alu_res;
                    ex_store_d  = fwd_b;
                    ex_reg_d    = bus.Reg1In;
                end
            end
            BUSY: begin
                if (mul_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (mul_done) begin
                    ex_rw_d     = mul_rw_q;
                    ex_result_d = mul_product;
                    ex_reg_d    = mul_reg_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            mul_reg_q   <= '0;
            mul_rw_q    <= 1'b0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            ex_mw_q     <= 1'b0;
            ex_result_q <= '0;
            ex_store_q  <= '0;
            ex_reg_q    <= '0;
        end else begin
            state_q     <= state_d;
            mul_reg_q   <= mul_reg_d;
            mul_rw_q    <= mul_rw_d;
            ex_rw_q     <= ex_rw_d;
            ex_mr_q     <= ex_mr_d;
            ex_mw_q     <= ex_mw_d;
            ex_result_q <= ex_result_d;
            ex_store_q  <= ex_store_d;
            ex_reg_q    <= ex_reg_d;
        end
    end

    assign bus.ExMemRegWrite  = ex_rw_q;
    assign bus.ExMemMemRead   = ex_mr_q;
    assign bus.ExMemMemWrite  = ex_mw_q;
    assign bus.ExMemResult    = ex_result_q;
    assign bus.ExMemStoreData = ex_store_q;
    assign bus.ExMemReg       = ex_reg_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed and randomized checks of ex_stage against a behavioural model of
// the EX/MEM register contents, forwarding rules and multiply timing.
module tb_ex_stage;

    logic Clk = 1'b0;
    logic Reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    ex_stage_if #(.DW(16)) bus ();

    ex_stage #(.DW(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Model of what EX/MEM should hold after the previous instruction.
    logic        m_rw, m_mr, m_mw;
    logic [15:0] m_res, m_sd;
    logic [2:0]  m_reg;

    task automatic m_clear();
        m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
        m_res = 16'h0; m_sd = 16'h0; m_reg = 3'd0;
    endtask

    function automatic logic [15:0] m_fwd(input logic [2:0] r, input logic [15:0] d,
                                          input logic wbrw, input logic [2:0] wbr,
                                          input logic [15:0] wbd);
        if (m_rw && !m_mr && (m_reg == r)) return m_res;
        if (wbrw && (wbr == r)) return wbd;
        return d;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] c, input logic [15:0] d1, input logic [15:0] d2,
                         input logic [7:0] imm, input logic [2:0] r1, input logic [2:0] r2,
                         input logic wbrw, input logic [2:0] wbr, input logic [15:0] wbd,
                         input logic [15:0] ja, input logic [15:0] jm);
        bus.ControlsIn    = c;
        bus.Data1In       = d1;
        bus.Data2In       = d2;
        bus.Imm8In        = imm;
        bus.Reg1In        = r1;
        bus.Reg2In        = r2;
        bus.MemWbRegWrite = wbrw;
        bus.MemWbReg      = wbr;
        bus.MemWbData     = wbd;
        bus.JEQAddrIn     = ja;
        bus.JMPAddrIn     = jm;
    endtask

    task automatic drive_bubble();
        drive(8'h00, 16'($urandom), 16'($urandom), 8'($urandom), 3'($urandom), 3'($urandom),
              1'b0, 3'd0, 16'h0, 16'($urandom), 16'($urandom));
    endtask

    task automatic chk_exmem(input string tag, input logic rw, input logic mr, input logic mw,
                             input logic [15:0] res, input logic [15:0] sd, input logic [2:0] rg);
        chk1({tag, ".regwrite"}, bus.ExMemRegWrite, rw);
        chk1({tag, ".memread"}, bus.ExMemMemRead, mr);
        chk1({tag, ".memwrite"}, bus.ExMemMemWrite, mw);
        chk16({tag, ".result"}, bus.ExMemResult, res);
        chk16({tag, ".store"}, bus.ExMemStoreData, sd);
        chk16({tag, ".reg"}, 16'(bus.ExMemReg), 16'(rg));
    endtask

    // One non-multiply instruction through EX, called just after a rising edge.
    task automatic issue(input string tag, input logic [7:0] c, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [7:0] imm, input logic [2:0] r1,
                         input logic [2:0] r2, input logic wbrw, input logic [2:0] wbr,
                         input logic [15:0] wbd, input logic [15:0] ja, input logic [15:0] jm);
        logic [15:0] fa, fb, ob, res, tgt;
        logic        take, wr;
        drive(c, d1, d2, imm, r1, r2, wbrw, wbr, wbd, ja, jm);
        fa   = m_fwd(r1, d1, wbrw, wbr, wbd);
        fb   = m_fwd(r2, d2, wbrw, wbr, wbd);
        ob   = c[4] ? {{8{imm[7]}}, imm} : fb;
        take = c[2] || (c[3] && (fa == fb));
        tgt  = !take ? 16'h0 : (c[2] ? jm : ja);
        wr   = (c != 8'h00) && !c[3] && !c[2];
        if (c[6] || c[5]) res = fa + ob;
        else if (c[1:0] == 2'b01) res = fa - ob;
        else if (c[1:0] == 2'b10) res = ~(fa & ob);
        else res = fa + ob;
        @(negedge Clk);
        chk1({tag, ".stall"}, bus.Stall, 1'b0);
        chk1({tag, ".pcload"}, bus.PcLoad, take);
        chk1({tag, ".flush"}, bus.Flush, take);
        chk16({tag, ".pctarget"}, bus.PcTarget, tgt);
        @(posedge Clk);
        #1;
        m_rw  = wr & c[7];
        m_mr  = wr & c[6];
        m_mw  = wr & c[5];
        m_res = wr ? res : 16'h0;
        m_sd  = wr ? fb : 16'h0;
        m_reg = wr ? r1 : 3'd0;
        chk_exmem(tag, m_rw, m_mr, m_mw, m_res, m_sd, m_reg);
    endtask

    // A multiply occupies EX for 18 cycles; Stall must be high for the first 17.
    task automatic mul_op(input string tag, input logic [15:0] d1, input logic [15:0] d2,
                          input logic [2:0] r1, input logic [2:0] r2, input logic rw,
                          input logic wbrw, input logic [2:0] wbr, input logic [15:0] wbd);
        logic [15:0] fa, fb;
        logic [31:0] full;
        int          hi_cnt;
        drive({rw, 5'b00000, 2'b11}, d1, d2, 8'h00, r1, r2, wbrw, wbr, wbd, 16'h0, 16'h0);
        fa     = m_fwd(r1, d1, wbrw, wbr, wbd);
        fb     = m_fwd(r2, d2, wbrw, wbr, wbd);
        full   = 32'(fa) * 32'(fb);
        hi_cnt = 0;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(negedge Clk);
            if (bus.Stall === 1'b1) hi_cnt++;
            chk1({tag, ".stall"}, bus.Stall, cyc <= 17);
            chk1({tag, ".flush"}, bus.Flush, 1'b0);
            @(posedge Clk);
            #1;
            if (cyc == 1) drive_bubble();
            if (cyc < 18) begin
                chk1({tag, ".bubble_rw"}, bus.ExMemRegWrite, 1'b0);
                chk16({tag, ".bubble_res"}, bus.ExMemResult, 16'h0);
            end
        end
        chk16({tag, ".stall_cycles"}, 16'(hi_cnt), 16'd17);
        m_rw = rw; m_mr = 1'b0; m_mw = 1'b0; m_res = full[15:0]; m_sd = 16'h0; m_reg = r1;
        chk1({tag, ".regwrite"}, bus.ExMemRegWrite, m_rw);
        chk1({tag, ".memread"}, bus.ExMemMemRead, 1'b0);
        chk1({tag, ".memwrite"}, bus.ExMemMemWrite, 1'b0);
        chk16({tag, ".product"}, bus.ExMemResult, m_res);
        chk16({tag, ".reg"}, 16'(bus.ExMemReg), 16'(m_reg));
    endtask

    initial begin
        logic [7:0]  c;
        logic [15:0] d1, d2;
        int          k;

        Reset = 1'b1;
        m_clear();
        drive(8'h04, 16'h1234, 16'h5678, 8'h12, 3'd1, 3'd2, 1'b1, 3'd1, 16'h9999,
              16'h00AA, 16'h00BB);
        @(negedge Clk);
        chk1("rst.stall", bus.Stall, 1'b0);
        chk1("rst.pcload", bus.PcLoad, 1'b0);
        chk1("rst.flush", bus.Flush, 1'b0);
        chk16("rst.pctarget", bus.PcTarget, 16'h0);
        @(posedge Clk);
        #1;
        chk_exmem("rst", 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
        drive_bubble();
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        issue("add", 8'h80, 16'd5, 16'd7, 8'h00, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
        chk16("add.twelve", bus.ExMemResult, 16'd12);
        issue("sub_fwd", 8'h81, 16'h1111, 16'd3, 8'h00, 3'd1, 3'd3, 1'b1, 3'd1, 16'h7777,
              16'h0, 16'h0);
        chk16("sub_fwd.nine", bus.ExMemResult, 16'd9);
        issue("wb_fwd", 8'h80, 16'h0001, 16'h0002, 8'h00, 3'd5, 3'd6, 1'b1, 3'd6, 16'h0100,
              16'h0, 16'h0);
        issue("load", 8'hD0, 16'h1000, 16'h0000, 8'hFE, 3'd7, 3'd0, 1'b0, 3'd0, 16'h0,
              16'h0, 16'h0);
        issue("no_fwd_load", 8'h80, 16'h0020, 16'h0001, 8'h00, 3'd7, 3'd0, 1'b0, 3'd0, 16'h0,
              16'h0, 16'h0);
        issue("store", 8'h30, 16'h0200, 16'hBEEF, 8'h04, 3'd2, 3'd3, 1'b0, 3'd0, 16'h0,
              16'h0, 16'h0);
        issue("nand", 8'h82, 16'hF0F0, 16'hFF00, 8'h00, 3'd4, 3'd5, 1'b0, 3'd0, 16'h0,
              16'h0, 16'h0);
        issue("jeq_eq", 8'h08, 16'h00AA, 16'h00AA, 8'h00, 3'd3, 3'd6, 1'b0, 3'd0, 16'h0,
              16'h0040, 16'h0000);
        issue("jeq_ne", 8'h08, 16'h00AA, 16'h00AB, 8'h00, 3'd3, 3'd6, 1'b0, 3'd0, 16'h0,
              16'h0040, 16'h0000);
        issue("jmp", 8'h04, 16'h0000, 16'h0000, 8'h00, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0,
              16'h0040, 16'h1234);
        issue("imm_neg", 8'h90, 16'h0005, 16'h0000, 8'h80, 3'd4, 3'd0, 1'b0, 3'd0, 16'h0,
              16'h0, 16'h0);
        issue("bubble", 8'h00, 16'h5555, 16'hAAAA, 8'h11, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0,
              16'h0, 16'h0);
        mul_op("mul_a", 16'h0123, 16'h0010, 3'd1, 3'd2, 1'b1, 1'b0, 3'd0, 16'h0);
        chk16("mul_a.value", bus.ExMemResult, 16'h1230);
        mul_op("mul_ff", 16'hFFFF, 16'hFFFF, 3'd3, 3'd4, 1'b1, 1'b0, 3'd0, 16'h0);
        chk16("mul_ff.value", bus.ExMemResult, 16'h0001);
        issue("mul_fwd", 8'h80, 16'h0000, 16'h0002, 8'h00, 3'd3, 3'd5, 1'b0, 3'd0, 16'h0,
              16'h0, 16'h0);

        // Reset arrives in the fifth BUSY cycle of a multiply.
        drive(8'h83, 16'h0005, 16'h0003, 8'h00, 3'd2, 3'd5, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
        @(posedge Clk);
        #1;
        drive_bubble();
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk);
            #1;
        end
        Reset = 1'b1;
        drive(8'h04, 16'h0, 16'h0, 8'h00, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 16'h0040, 16'h4321);
        @(negedge Clk);
        chk1("midrst.stall", bus.Stall, 1'b0);
        chk1("midrst.pcload", bus.PcLoad, 1'b0);
        chk1("midrst.flush", bus.Flush, 1'b0);
        chk16("midrst.pctarget", bus.PcTarget, 16'h0);
        @(posedge Clk);
        #1;
        chk_exmem("midrst", 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
        Reset = 1'b0;
        m_clear();
        issue("add_after_rst", 8'h80, 16'd1, 16'd2, 8'h00, 3'd3, 3'd4, 1'b0, 3'd0, 16'h0,
              16'h0, 16'h0);
        chk16("add_after_rst.three", bus.ExMemResult, 16'd3);
        for (int i = 0; i < 16; i++) begin
            issue("post_rst_idle", 8'h00, 16'($urandom), 16'($urandom), 8'h00, 3'd0, 3'd0,
                  1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
        end

        for (int i = 0; i < 70; i++) begin
            k  = $urandom_range(0, 10);
            d1 = 16'($urandom);
            d2 = ($urandom_range(0, 1) == 1) ? d1 : 16'($urandom);
            if (k == 10) begin
                mul_op("rnd_mul", d1, d2, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 3)), 16'($urandom));
            end else begin
                case (k)
                    0: c = 8'h00;
                    1: c = 8'h08;
                    2: c = 8'h04;
                    3: c = 8'hD0;
                    4: c = 8'h30;
                    default: c = {1'($urandom_range(0, 1)), 2'b00, 1'($urandom_range(0, 1)),
                                  2'b00, 2'($urandom_range(0, 2))};
                endcase
                issue("rnd", c, d1, d2, 8'($urandom), 3'($urandom_range(0, 3)),
                      3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 16'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
